// File: rtl/jacobi_pair_scheduler_pkg.sv
// Shared constants and FSM state type for the parallel Jacobi pair scheduler.
package jacobi_pair_scheduler_pkg;

    localparam int JACOBI_N            = 8;
    localparam int JACOBI_LOG2_N       = 3;
    localparam int JACOBI_N_PAIRS      = JACOBI_N / 2;
    localparam int JACOBI_LOG2_N_PAIRS = 2;
    localparam int JACOBI_N_ROUNDS     = 4 * (JACOBI_N - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } jacobi_sched_state_t;

endpackage

// File: rtl/jacobi_pair_order.sv
// Round-robin tournament ordering: pos[0] is pinned, pos[1..N-1] rotate each round.
// Presents the sorted (p,q) pair for the requested slot combinationally.
module jacobi_pair_order
    import jacobi_pair_scheduler_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_load,
    input  logic                           i_rotate,
    input  logic [JACOBI_LOG2_N_PAIRS-1:0] i_slot,
    output logic [JACOBI_LOG2_N-1:0]       o_p,
    output logic [JACOBI_LOG2_N-1:0]       o_q
);

    logic [JACOBI_LOG2_N-1:0] r_pos [JACOBI_N];
    logic [JACOBI_LOG2_N-1:0] w_lo_idx;
    logic [JACOBI_LOG2_N-1:0] w_hi_idx;
    logic [JACOBI_LOG2_N-1:0] w_a;
    logic [JACOBI_LOG2_N-1:0] w_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < JACOBI_N; i++) r_pos[i] <= JACOBI_LOG2_N'(i);
        end else if (i_load) begin
            for (int i = 0; i < JACOBI_N; i++) r_pos[i] <= JACOBI_LOG2_N'(i);
        end else if (i_rotate) begin
            r_pos[1] <= r_pos[JACOBI_N-1];
            for (int i = 2; i < JACOBI_N; i++) r_pos[i] <= r_pos[i-1];
        end
    end

    // Slot k pairs position k with its mirror N-1-k.
    always_comb begin
        w_lo_idx = JACOBI_LOG2_N'(i_slot);
        w_hi_idx = JACOBI_LOG2_N'(JACOBI_N - 1) - w_lo_idx;
        w_a      = r_pos[w_lo_idx];
        w_b      = r_pos[w_hi_idx];
        o_p      = (w_a < w_b) ? w_a : w_b;
        o_q      = (w_a < w_b) ? w_b : w_a;
    end

endmodule

// File: rtl/jacobi_pair_scheduler.sv
// Issues JACOBI_N_PAIRS disjoint rotation pairs per round for JACOBI_N_ROUNDS rounds.
// Optional convergence early exit at sweep boundaries: define JACOBI_SCHED_EARLY_EXIT_EN.
module jacobi_pair_scheduler
    import jacobi_pair_scheduler_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic                           pair_valid,
    input  logic                           pair_ready,
    output logic [JACOBI_LOG2_N-1:0]       pair_p,
    output logic [JACOBI_LOG2_N-1:0]       pair_q,
    output logic [JACOBI_LOG2_N_PAIRS-1:0] pair_idx,
    input  logic                           rot_done,
    output logic [4:0]                     round_idx,
    output logic                           busy,
    output logic                           done,
`ifdef JACOBI_SCHED_EARLY_EXIT_EN
    input  logic                           converged,
`endif
    output logic                           err
);

    localparam int CNT_W = JACOBI_LOG2_N_PAIRS + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(JACOBI_N_PAIRS);

    jacobi_sched_state_t              r_state;
    jacobi_sched_state_t              w_state_nxt;
    logic [JACOBI_LOG2_N_PAIRS-1:0]   r_pair_idx;
    logic [4:0]                       r_round_idx;
    logic [CNT_W-1:0]                 r_issue_cnt;
    logic [CNT_W-1:0]                 r_done_cnt;
    logic                             r_err;

    logic                             w_hs;
    logic                             w_active;
    logic [CNT_W-1:0]                 w_issue_nxt;
    logic [CNT_W-1:0]                 w_done_nxt;
    logic                             w_rd_ok;
    logic                             w_rd_bad;
    logic                             w_round_cmpl;
    logic                             w_exit;
    logic                             w_load;
    logic                             w_rotate;
    logic [JACOBI_LOG2_N-1:0]         w_p;
    logic [JACOBI_LOG2_N-1:0]         w_q;
`ifdef JACOBI_SCHED_EARLY_EXIT_EN
    logic [5:0]                       w_rnd_p1;
    logic                             w_sweep_end;
`endif

    jacobi_pair_order u_order (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_rotate (w_rotate),
        .i_slot   (r_pair_idx),
        .o_p      (w_p),
        .o_q      (w_q)
    );

    // A retirement is legal only while it does not outrun the handshakes,
    // including one landing in the same cycle.
    always_comb begin
        w_active     = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
        w_hs         = (r_state == ST_ISSUE) && pair_ready;
        w_issue_nxt  = r_issue_cnt + CNT_W'(w_hs);
        w_rd_ok      = w_active && rot_done && (r_done_cnt < w_issue_nxt);
        w_rd_bad     = w_active && rot_done && !(r_done_cnt < w_issue_nxt);
        w_done_nxt   = r_done_cnt + CNT_W'(w_rd_ok);
        w_round_cmpl = w_active && (w_issue_nxt == CNT_FULL) && (w_done_nxt == CNT_FULL);
`ifdef JACOBI_SCHED_EARLY_EXIT_EN
        w_rnd_p1     = {1'b0, r_round_idx} + 6'd1;
        w_sweep_end  = (w_rnd_p1 % 6'(JACOBI_N - 1)) == 6'd0;
        w_exit       = (r_round_idx == 5'(JACOBI_N_ROUNDS - 1)) || (w_sweep_end && converged);
`else
        w_exit       = (r_round_idx == 5'(JACOBI_N_ROUNDS - 1));
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_rotate    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_ISSUE;
                    w_load      = 1'b1;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (w_round_cmpl) begin
                    w_state_nxt = w_exit ? ST_FINISH : ST_ISSUE;
                    w_rotate    = !w_exit;
                end else if (w_hs && (r_pair_idx == JACOBI_LOG2_N_PAIRS'(JACOBI_N_PAIRS - 1))) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pair_idx  <= '0;
            r_round_idx <= '0;
            r_issue_cnt <= '0;
            r_done_cnt  <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_load) begin
                r_pair_idx  <= '0;
                r_round_idx <= '0;
                r_issue_cnt <= '0;
                r_done_cnt  <= '0;
                r_err       <= 1'b0;
            end else if (w_rotate) begin
                r_pair_idx  <= '0;
                r_round_idx <= r_round_idx + 5'd1;
                r_issue_cnt <= '0;
                r_done_cnt  <= '0;
            end else begin
                if (w_hs) begin
                    r_pair_idx  <= r_pair_idx + JACOBI_LOG2_N_PAIRS'(1);
                    r_issue_cnt <= w_issue_nxt;
                end
                if (w_rd_ok) r_done_cnt <= w_done_nxt;
            end
            if (w_rd_bad) r_err <= 1'b1;
        end
    end

    // Pair outputs read zero whenever nothing is offered.
    always_comb begin
        pair_valid = (r_state == ST_ISSUE);
        pair_p     = pair_valid ? w_p : '0;
        pair_q     = pair_valid ? w_q : '0;
        pair_idx   = r_pair_idx;
        round_idx  = r_round_idx;
        busy       = w_active;
        done       = (r_state == ST_FINISH);
        err        = r_err;
    end

endmodule

// File: tb/tb_jacobi_pair_scheduler.sv
// Scoreboard bench for jacobi_pair_scheduler against a tournament-schedule reference model.
`timescale 1ns/1ps
module tb_jacobi_pair_scheduler;
    import jacobi_pair_scheduler_pkg::*;

    localparam int NN = JACOBI_N;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pair_ready = 1'b0;
    logic       rot_done = 1'b0;
    logic       pair_valid;
    logic [2:0] pair_p;
    logic [2:0] pair_q;
    logic [1:0] pair_idx;
    logic [4:0] round_idx;
    logic       busy;
    logic       done;
    logic       err;
`ifdef JACOBI_SCHED_EARLY_EXIT_EN
    logic       converged = 1'b0;
`endif

    always #5 clk = ~clk;

    jacobi_pair_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .pair_p     (pair_p),
        .pair_q     (pair_q),
        .pair_idx   (pair_idx),
        .rot_done   (rot_done),
        .round_idx  (round_idx),
        .busy       (busy),
        .done       (done),
`ifdef JACOBI_SCHED_EARLY_EXIT_EN
        .converged  (converged),
`endif
        .err        (err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: in round r, position i>0 holds player ((i-1-r) mod (N-1)) + 1.
    function automatic int pos_of(input int r, input int i);
        if (i == 0) return 0;
        return (((i - 1 - r) % (NN - 1)) + (NN - 1)) % (NN - 1) + 1;
    endfunction

    typedef struct { int rnd; int idx; int p; int q; } exp_t;
    exp_t exp_q[$];

    task automatic push_run(input int nrounds);
        for (int r = 0; r < nrounds; r++) begin
            for (int k = 0; k < NN/2; k++) begin
                int a;
                int b;
                a = pos_of(r, k);
                b = pos_of(r, NN - 1 - k);
                exp_q.push_back('{r, k, (a < b) ? a : b, (a < b) ? b : a});
            end
        end
    endtask

    // Knobs written only by the main sequence.
    int ready_pct = 100;
    int dmin = 19;
    int dmax = 19;
    bit stall2 = 0;
    bit same_mode = 0;
    bit hold_ready = 0;
    int conv_round = -1;
    int inj_req = 0;

    // Driver: retirement timing, ready pattern, injected rot_done pulses.
    int cyc = 0;
    int inj_ack = 0;
    int due_q[$];
    int stall_cnt = 0;
    bit sc_skip = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                due_q.delete();
                sc_skip = 0;
            end else if (pair_valid && pair_ready) begin
                if (sc_skip) sc_skip = 0;
                else due_q.push_back(cyc + int'($urandom_range(dmax, dmin)));
            end
            @(posedge clk);
            cyc++;
            #1;
            rot_done = 1'b0;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                void'(due_q.pop_front());
                rot_done = 1'b1;
            end else if (inj_ack != inj_req) begin
                inj_ack++;
                rot_done = 1'b1;
            end
            if (hold_ready) begin
                pair_ready = 1'b0;
            end else if (same_mode && pair_valid && pair_idx == 2'd3) begin
                pair_ready = (due_q.size() == 0) && !rot_done;
                if (pair_ready) begin
                    rot_done = 1'b1;
                    sc_skip  = 1;
                end
            end else if (stall2 && pair_valid && pair_idx == 2'd2 && stall_cnt < 5) begin
                pair_ready = 1'b0;
                stall_cnt++;
            end else begin
                pair_ready = ($urandom_range(99, 0) < ready_pct);
                if (!(pair_valid && pair_idx == 2'd2)) stall_cnt = 0;
            end
`ifdef JACOBI_SCHED_EARLY_EXIT_EN
            converged = (conv_round >= 0) && (int'(round_idx) == conv_round);
`endif
        end
    end

    // Monitor: pops the scoreboard on every handshake.
    int hs_total = 0;
    int done_total = 0;
    int qsize_at_done = 0;
    int sc_total = 0;
    int cov [NN][NN] = '{default: 0};
    bit prev_stall = 0;
    bit exp_after_sc = 0;
    logic [2:0] prev_p;
    logic [2:0] prev_q;
    logic [1:0] prev_idx;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall   = 0;
            exp_after_sc = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", pair_valid, 1);
                check("stall_p", pair_p, prev_p);
                check("stall_q", pair_q, prev_q);
                check("stall_idx", pair_idx, prev_idx);
            end
            if (exp_after_sc) begin
                check("samecycle_next_valid", pair_valid, 1);
                check("samecycle_next_idx", pair_idx, 0);
                exp_after_sc = 0;
            end
            prev_stall = pair_valid && !pair_ready;
            prev_p     = pair_p;
            prev_q     = pair_q;
            prev_idx   = pair_idx;
            if (pair_valid && pair_ready) begin
                hs_total++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pair: got (%0d,%0d) round %0d, expected none", pair_p, pair_q, round_idx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pair_round", round_idx, e.rnd);
                    check("pair_idx", pair_idx, e.idx);
                    check("pair_p", pair_p, e.p);
                    check("pair_q", pair_q, e.q);
                end
                cov[pair_p][pair_q]++;
                if (same_mode && rot_done && pair_idx == 2'd3) begin
                    sc_total++;
                    if (round_idx != 5'(JACOBI_N_ROUNDS - 1)) exp_after_sc = 1;
                end
            end
            if (done) begin
                done_total++;
                qsize_at_done = exp_q.size();
                check("done_busy_low", busy, 0);
                check("done_valid_low", pair_valid, 0);
            end
        end
    end

    task automatic do_start(input int nrounds);
        push_run(nrounds);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input int d0);
        int n;
        n = 0;
        while (done_total == d0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("done_seen", done_total - d0, 1);
        check("busy_after_done", busy, 0);
        repeat (4) @(posedge clk);
        #1;
        check("done_single", done_total - d0, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, pair_valid, 0);
        check({tag, "_p"}, pair_p, 0);
        check({tag, "_q"}, pair_q, 0);
        check({tag, "_idx"}, pair_idx, 0);
        check({tag, "_round"}, round_idx, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        int h0;
        int d0;
        int s0;
        int nbad;
        bit reached;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Nominal run: 19-cycle retirement latency.
        h0 = hs_total; d0 = done_total;
        do_start(JACOBI_N_ROUNDS);
        check("first_valid", pair_valid, 1);
        check("first_busy", busy, 1);
        check("first_p", pair_p, 0);
        check("first_q", pair_q, 7);
        wait_done(20000, d0);
        check("run_a_handshakes", hs_total - h0, 112);
        check("run_a_leftover", qsize_at_done, 0);
        check("run_a_round_hold", round_idx, JACOBI_N_ROUNDS - 1);
        check("run_a_err", err, 0);
        nbad = 0;
        for (int p = 0; p < NN; p++)
            for (int q = 0; q < NN; q++)
                if ((p < q && cov[p][q] != 4) || (p >= q && cov[p][q] != 0)) nbad++;
        check("run_a_coverage", nbad, 0);

        // Random ready/latency, slot-2 stalls, stray start while busy.
        ready_pct = 70; dmin = 1; dmax = 8; stall2 = 1;
        h0 = hs_total; d0 = done_total;
        do_start(JACOBI_N_ROUNDS);
        repeat (40) @(posedge clk);
        pulse_start();
        wait_done(20000, d0);
        check("run_b_handshakes", hs_total - h0, 112);
        check("run_b_leftover", qsize_at_done, 0);
        check("run_b_err", err, 0);

        // Last slot retires in its own handshake cycle.
        ready_pct = 100; dmin = 3; dmax = 3; stall2 = 0; same_mode = 1;
        h0 = hs_total; d0 = done_total; s0 = sc_total;
        do_start(JACOBI_N_ROUNDS);
        wait_done(20000, d0);
        check("run_c_handshakes", hs_total - h0, 112);
        check("run_c_samecycle_events", sc_total - s0, JACOBI_N_ROUNDS);
        check("run_c_leftover", qsize_at_done, 0);
        same_mode = 0;

        // Stray rot_done with nothing outstanding.
        dmin = 19; dmax = 19; hold_ready = 1;
        h0 = hs_total; d0 = done_total;
        do_start(JACOBI_N_ROUNDS);
        repeat (2) @(posedge clk);
        inj_req++;
        repeat (3) @(posedge clk);
        #1;
        check("err_set", err, 1);
        check("err_no_issue", pair_idx, 0);
        hold_ready = 0;
        wait_done(20000, d0);
        check("err_sticky", err, 1);
        check("run_d_handshakes", hs_total - h0, 112);

        // Next start clears err; reset mid-run at round 10.
        do_start(JACOBI_N_ROUNDS);
        check("err_cleared", err, 0);
        reached = 0;
        for (int n = 0; n < 5000 && !reached; n++) begin
            @(negedge clk);
            if (round_idx == 5'd10 && busy) reached = 1;
        end
        check("reached_round10", reached, 1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midrun_reset");
        h0 = hs_total;
        repeat (3) @(negedge clk);
        check("reset_hold_valid", pair_valid, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("after_reset_valid", pair_valid, 0);
        check("after_reset_hs", hs_total - h0, 0);

`ifdef JACOBI_SCHED_EARLY_EXIT_EN
        conv_round = 13;
        h0 = hs_total; d0 = done_total;
        do_start(JACOBI_N_ROUNDS);
        wait_done(20000, d0);
        check("early_round", round_idx, 13);
        check("early_handshakes", hs_total - h0, 56);
        check("early_leftover", qsize_at_done, 56);
        exp_q.delete();
        conv_round = -1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
